// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: fetch/decode/execute sequencing for lw, sw,
// R-type, beq, addi, andi and j, with memory-ready stalls and illegal-opcode flagging.
module multicycle_control #(
    parameter int OPW     = 6,
    parameter bit ANDI_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           PCWrite,
    output logic           Branch,
    output logic           RegDst,
    output logic           MemtoReg,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSrc,
    output logic           illegal_op,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REX    = 4'd6,
        ALUWB  = 4'd7,
        BEQEX  = 4'd8,
        IMMEX  = 4'd9,
        IMMWB  = 4'd10,
        JEX    = 4'd11
    } state_t;

    // Instruction class remembered past DECODE so opcode is don't-care afterwards.
    typedef enum logic [1:0] {
        CLS_LW   = 2'd0,
        CLS_SW   = 2'd1,
        CLS_ADDI = 2'd2,
        CLS_ANDI = 2'd3
    } cls_t;

    state_t state_r;
    state_t state_s;
    cls_t   cls_r;
    cls_t   cls_s;

    // Zero-extended compare: any set bit above bit 5 makes the match fail.
    function automatic logic op_is(input logic [OPW-1:0] op, input logic [5:0] code);
        return op == OPW'(code);
    endfunction

    assign state = state_r;

    // State and instruction-class registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
            cls_r   <= CLS_LW;
        end else begin
            state_r <= state_s;
            cls_r   <= cls_s;
        end
    end

    // Next-state and Moore/Mealy control outputs.
    always_comb begin
        state_s    = state_r;
        cls_s      = cls_r;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        case (state_r)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // Write enables are masked while reset is held, whatever mem_ready says.
                IRWrite = mem_ready & rst_n;
                PCWrite = mem_ready & rst_n;
                if (mem_ready) begin
                    state_s = DECODE;
                end else begin
                    state_s = FETCH;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                if (op_is(opcode, 6'h00)) begin
                    state_s = REX;
                end else if (op_is(opcode, 6'h23)) begin
                    state_s = MEMADR;
                    cls_s   = CLS_LW;
                end else if (op_is(opcode, 6'h2B)) begin
                    state_s = MEMADR;
                    cls_s   = CLS_SW;
                end else if (op_is(opcode, 6'h04)) begin
                    state_s = BEQEX;
                end else if (op_is(opcode, 6'h08)) begin
                    state_s = IMMEX;
                    cls_s   = CLS_ADDI;
                end else if (ANDI_EN && op_is(opcode, 6'h0C)) begin
                    state_s = IMMEX;
                    cls_s   = CLS_ANDI;
                end else if (op_is(opcode, 6'h02)) begin
                    state_s = JEX;
                end else begin
                    state_s    = FETCH;
                    illegal_op = 1'b1;
                end
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (cls_r == CLS_SW) begin
                    state_s = MEMWR;
                end else begin
                    state_s = MEMRD;
                end
            end
            MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    state_s = MEMWB;
                end else begin
                    state_s = MEMRD;
                end
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_s  = FETCH;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    state_s = FETCH;
                end else begin
                    state_s = MEMWR;
                end
            end
            REX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_s = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_s  = FETCH;
            end
            BEQEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
                state_s = FETCH;
            end
            IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (cls_r == CLS_ANDI) begin
                    ALUOp = 2'b11;
                end else begin
                    ALUOp = 2'b00;
                end
                state_s = IMMWB;
            end
            IMMWB: begin
                RegWrite = 1'b1;
                state_s  = FETCH;
            end
            JEX: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                state_s = FETCH;
            end
            default: begin
                state_s = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a default instance (OPW=6, andi enabled)
// and a second instance with OPW=8 and andi disabled, checked against hand-computed vectors.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n, rst8_n;
    logic       mem_ready, mem_ready8;
    logic [5:0] opcode;
    logic [7:0] opcode8;

    logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state;

    logic       IorD8, MemRead8, MemWrite8, IRWrite8, PCWrite8, Branch8;
    logic       RegDst8, MemtoReg8, RegWrite8, ALUSrcA8, illegal_op8;
    logic [1:0] ALUSrcB8, ALUOp8, PCSrc8;
    logic [3:0] state8;

    int total = 0;
    int bad   = 0;

    // Control word: IorD MemRead MemWrite IRWrite PCWrite Branch RegDst MemtoReg
    //               RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSrc[1:0] illegal_op
    localparam logic [16:0] C_FETCH_RDY = 17'h0B020;
    localparam logic [16:0] C_FETCH_IDL = 17'h08020;
    localparam logic [16:0] C_DECODE    = 17'h00060;
    localparam logic [16:0] C_DEC_ILL   = 17'h00061;
    localparam logic [16:0] C_MEMADR    = 17'h000C0;
    localparam logic [16:0] C_MEMRD     = 17'h18000;
    localparam logic [16:0] C_MEMWB     = 17'h00300;
    localparam logic [16:0] C_MEMWR     = 17'h14000;
    localparam logic [16:0] C_REX       = 17'h00090;
    localparam logic [16:0] C_ALUWB     = 17'h00500;
    localparam logic [16:0] C_BEQEX     = 17'h0088A;
    localparam logic [16:0] C_ADDIEX    = 17'h000C0;
    localparam logic [16:0] C_ANDIEX    = 17'h000D8;
    localparam logic [16:0] C_IMMWB     = 17'h00100;
    localparam logic [16:0] C_JEX       = 17'h01004;

    wire [16:0] ctl  = {IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, RegDst, MemtoReg,
                        RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op};
    wire [16:0] ctl8 = {IorD8, MemRead8, MemWrite8, IRWrite8, PCWrite8, Branch8, RegDst8, MemtoReg8,
                        RegWrite8, ALUSrcA8, ALUSrcB8, ALUOp8, PCSrc8, illegal_op8};

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .illegal_op(illegal_op), .state(state)
    );

    multicycle_control #(.OPW(8), .ANDI_EN(1'b0)) dut8 (
        .clk(clk), .rst_n(rst8_n), .opcode(opcode8), .mem_ready(mem_ready8),
        .IorD(IorD8), .MemRead(MemRead8), .MemWrite(MemWrite8), .IRWrite(IRWrite8),
        .PCWrite(PCWrite8), .Branch(Branch8), .RegDst(RegDst8), .MemtoReg(MemtoReg8),
        .RegWrite(RegWrite8), .ALUSrcA(ALUSrcA8), .ALUSrcB(ALUSrcB8), .ALUOp(ALUOp8),
        .PCSrc(PCSrc8), .illegal_op(illegal_op8), .state(state8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the default instance, then advance to the next falling edge.
    task automatic step(input string tag, input logic [3:0] es, input logic [16:0] ec);
        #1;
        chk({tag, ".state"}, {13'd0, state}, {13'd0, es});
        chk({tag, ".ctl"}, ctl, ec);
        @(negedge clk);
    endtask

    task automatic step8(input string tag, input logic [3:0] es, input logic [16:0] ec);
        #1;
        chk({tag, ".state"}, {13'd0, state8}, {13'd0, es});
        chk({tag, ".ctl"}, ctl8, ec);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rst8_n = 1'b0;
        mem_ready = 1'b1; mem_ready8 = 1'b1;
        opcode = 6'h3F; opcode8 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst8.state", {13'd0, state8}, 17'd0);
        chk("rst8.ctl", ctl8, C_FETCH_IDL);
        step("rst", 4'd0, C_FETCH_IDL);

        // lw, mem_ready=1: 0,1,2,3,4; opcode scrambled after DECODE
        rst_n = 1'b1;
        step("lw.f", 4'd0, C_FETCH_RDY);
        opcode = 6'h23;
        step("lw.d", 4'd1, C_DECODE);
        opcode = 6'h3F;
        step("lw.ma", 4'd2, C_MEMADR);
        step("lw.mr", 4'd3, C_MEMRD);
        step("lw.wb", 4'd4, C_MEMWB);

        // sw with three stall cycles in MEMWR
        step("sw.f", 4'd0, C_FETCH_RDY);
        opcode = 6'h2B;
        step("sw.d", 4'd1, C_DECODE);
        opcode = 6'h00;
        step("sw.ma", 4'd2, C_MEMADR);
        mem_ready = 1'b0;
        step("sw.mw0", 4'd5, C_MEMWR);
        step("sw.mw1", 4'd5, C_MEMWR);
        step("sw.mw2", 4'd5, C_MEMWR);
        mem_ready = 1'b1;
        step("sw.mw3", 4'd5, C_MEMWR);

        // R-type, preceded by a FETCH stall
        mem_ready = 1'b0;
        step("r.fstall", 4'd0, C_FETCH_IDL);
        mem_ready = 1'b1;
        step("r.f", 4'd0, C_FETCH_RDY);
        opcode = 6'h00;
        step("r.d", 4'd1, C_DECODE);
        step("r.ex", 4'd6, C_REX);
        step("r.wb", 4'd7, C_ALUWB);

        step("addi.f", 4'd0, C_FETCH_RDY);
        opcode = 6'h08;
        step("addi.d", 4'd1, C_DECODE);
        step("addi.ex", 4'd9, C_ADDIEX);
        step("addi.wb", 4'd10, C_IMMWB);

        step("andi.f", 4'd0, C_FETCH_RDY);
        opcode = 6'h0C;
        step("andi.d", 4'd1, C_DECODE);
        opcode = 6'h08;
        step("andi.ex", 4'd9, C_ANDIEX);
        step("andi.wb", 4'd10, C_IMMWB);

        step("beq.f", 4'd0, C_FETCH_RDY);
        opcode = 6'h04;
        step("beq.d", 4'd1, C_DECODE);
        step("beq.ex", 4'd8, C_BEQEX);

        step("j.f", 4'd0, C_FETCH_RDY);
        opcode = 6'h02;
        step("j.d", 4'd1, C_DECODE);
        step("j.ex", 4'd11, C_JEX);

        step("ill.f", 4'd0, C_FETCH_RDY);
        opcode = 6'h3F;
        step("ill.d", 4'd1, C_DEC_ILL);

        // Reset pulsed while MEMRD is stalled
        step("rst.f", 4'd0, C_FETCH_RDY);
        opcode = 6'h23;
        step("rst.d", 4'd1, C_DECODE);
        step("rst.ma", 4'd2, C_MEMADR);
        mem_ready = 1'b0;
        step("rst.mr0", 4'd3, C_MEMRD);
        mem_ready = 1'b1;
        #1;
        chk("rst.mr1.state", {13'd0, state}, 17'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.async.state", {13'd0, state}, 17'd0);
        chk("rst.async.ctl", ctl, C_FETCH_IDL);
        @(negedge clk);
        step("rst.held", 4'd0, C_FETCH_IDL);
        rst_n = 1'b1;
        opcode = 6'h00;
        step("rst.rel", 4'd0, C_FETCH_RDY);
        step("rst.resume", 4'd1, C_DECODE);

        // OPW=8, ANDI_EN=0 instance
        rst8_n = 1'b1;
        opcode8 = 8'h40;
        step8("w8.f0", 4'd0, C_FETCH_RDY);
        step8("w8.ill40", 4'd1, C_DEC_ILL);
        opcode8 = 8'h0C;
        step8("w8.f1", 4'd0, C_FETCH_RDY);
        step8("w8.andi_off", 4'd1, C_DEC_ILL);
        opcode8 = 8'hA3;
        step8("w8.f2", 4'd0, C_FETCH_RDY);
        step8("w8.illA3", 4'd1, C_DEC_ILL);
        opcode8 = 8'h23;
        step8("w8.f3", 4'd0, C_FETCH_RDY);
        step8("w8.lw.d", 4'd1, C_DECODE);
        step8("w8.lw.ma", 4'd2, C_MEMADR);
        step8("w8.lw.mr", 4'd3, C_MEMRD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
